// File: rtl/svm_infer_ctrl.sv
// svm_infer_ctrl: sequencing/configuration controller in front of kernel_svm.
// Keeps a shadow and an active copy of the SVM model, runs exactly one
// inference at a time (IDLE -> ISSUE -> WAIT -> RESP), and returns either the
// kernel's answer or a timeout response on a valid/ready port.
module svm_infer_ctrl #(
   parameter int unsigned DATA_WIDTH          = 16,
   parameter int unsigned NUM_FEATURES        = 16,
   parameter int unsigned NUM_SUPPORT_VECTORS = 16,
   parameter int unsigned ADDR_W              = 9,
   parameter int unsigned TAG_W               = 4,
   parameter int unsigned TIMEOUT_CYCLES      = 64
) (
   input  logic                                                  clk,
   input  logic                                                  rst_n,
   // model configuration
   input  logic                                                  cfg_wr_en,
   input  logic [ADDR_W-1:0]                                     cfg_addr,
   input  logic [DATA_WIDTH-1:0]                                 cfg_wdata,
   input  logic                                                  cfg_commit,
   output logic                                                  cfg_err,
   output logic [7:0]                                            model_version,
   // request port
   input  logic                                                  req_valid,
   output logic                                                  req_ready,
   input  logic [DATA_WIDTH*NUM_FEATURES-1:0]                    req_features_flat,
   input  logic [TAG_W-1:0]                                      req_tag,
   // response port
   output logic                                                  rsp_valid,
   input  logic                                                  rsp_ready,
   output logic [DATA_WIDTH-1:0]                                 rsp_decision,
   output logic                                                  rsp_prediction,
   output logic [TAG_W-1:0]                                      rsp_tag,
   output logic                                                  rsp_timeout,
   // kernel_svm side
   output logic                                                  svm_input_valid,
   output logic [DATA_WIDTH*NUM_FEATURES-1:0]                    svm_features_flat,
   output logic [DATA_WIDTH*NUM_FEATURES*NUM_SUPPORT_VECTORS-1:0] svm_sv_flat,
   output logic [DATA_WIDTH*NUM_SUPPORT_VECTORS-1:0]             svm_dual_coef_flat,
   output logic [DATA_WIDTH-1:0]                                 svm_bias,
   input  logic                                                  svm_output_valid,
   input  logic [DATA_WIDTH-1:0]                                 svm_decision_value,
   input  logic                                                  svm_prediction
);

   localparam int unsigned NUM_SV_WORDS = NUM_FEATURES * NUM_SUPPORT_VECTORS;
   localparam int unsigned COEF_BASE    = NUM_SV_WORDS;
   localparam int unsigned BIAS_ADDR    = NUM_SV_WORDS + NUM_SUPPORT_VECTORS;
   localparam int unsigned SV_IW        = (NUM_SV_WORDS > 1) ? $clog2(NUM_SV_WORDS) : 1;
   localparam int unsigned CO_IW        = (NUM_SUPPORT_VECTORS > 1) ? $clog2(NUM_SUPPORT_VECTORS) : 1;
   localparam int unsigned CNT_W        = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int unsigned FEAT_W       = DATA_WIDTH * NUM_FEATURES;
   localparam int unsigned SV_W         = DATA_WIDTH * NUM_SV_WORDS;
   localparam int unsigned COEF_W       = DATA_WIDTH * NUM_SUPPORT_VECTORS;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_RESP
   } state_e;

   state_e                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    pending_q, pending_d;
   logic                    apply_commit;
   logic [7:0]              version_q, version_d;
   logic                    req_ready_q, req_ready_d;
   logic                    in_valid_q, in_valid_d;
   logic                    rsp_valid_q, rsp_valid_d;
   logic [DATA_WIDTH-1:0]   rsp_dec_q, rsp_dec_d;
   logic                    rsp_pred_q, rsp_pred_d;
   logic [TAG_W-1:0]        rsp_tag_q, rsp_tag_d;
   logic                    rsp_tmo_q, rsp_tmo_d;
   logic [FEAT_W-1:0]       feat_q, feat_d;
   logic [TAG_W-1:0]        tag_q, tag_d;

   logic [SV_W-1:0]         shadow_sv_q, active_sv_q;
   logic [COEF_W-1:0]       shadow_coef_q, active_coef_q;
   logic [DATA_WIDTH-1:0]   shadow_bias_q, active_bias_q;
   logic                    cfg_err_q;

   logic                    sv_wr, coef_wr, bias_wr, addr_oob;
   logic [SV_IW-1:0]        sv_idx;
   logic [CO_IW-1:0]        coef_idx;

   // Decode the configuration address into SV / coefficient / bias / out-of-range.
   always_comb begin
      // NOTE: every signal driven here gets a value on every path (defaults first),
      // otherwise synthesis infers a latch to hold the old value.
      sv_wr    = 1'b0;
      coef_wr  = 1'b0;
      bias_wr  = 1'b0;
      addr_oob = 1'b0;
      sv_idx   = SV_IW'(cfg_addr);
      coef_idx = CO_IW'(cfg_addr - ADDR_W'(COEF_BASE));
      if (cfg_wr_en) begin
         if (cfg_addr < ADDR_W'(COEF_BASE))      sv_wr    = 1'b1;
         else if (cfg_addr < ADDR_W'(BIAS_ADDR)) coef_wr  = 1'b1;
         else if (cfg_addr == ADDR_W'(BIAS_ADDR)) bias_wr = 1'b1;
         else                                    addr_oob = 1'b1;
      end
   end

   // Next-state, pending-commit and registered-output logic of the inference FSM.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      feat_d       = feat_q;
      tag_d        = tag_q;
      rsp_dec_d    = rsp_dec_q;
      rsp_pred_d   = rsp_pred_q;
      rsp_tag_d    = rsp_tag_q;
      rsp_tmo_d    = rsp_tmo_q;
      apply_commit = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // A pending commit always beats a new request.
            if (pending_q) begin
               apply_commit = 1'b1;
            end else if (req_valid && req_ready_q) begin
               feat_d  = req_features_flat;
               tag_d   = req_tag;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            cnt_d   = '0;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            // An answer in the same cycle as the limit still wins.
            if (svm_output_valid) begin
               rsp_dec_d  = svm_decision_value;
               rsp_pred_d = svm_prediction;
               rsp_tag_d  = tag_q;
               rsp_tmo_d  = 1'b0;
               state_d    = ST_RESP;
            end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               rsp_dec_d  = '0;
               rsp_pred_d = 1'b0;
               rsp_tag_d  = tag_q;
               rsp_tmo_d  = 1'b1;
               state_d    = ST_RESP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_RESP: begin
            if (rsp_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // Repeated commits while pending collapse into a single one.
      pending_d   = cfg_commit | (pending_q & ~apply_commit);
      version_d   = apply_commit ? version_q + 8'd1 : version_q;
      req_ready_d = (state_d == ST_IDLE) && !pending_d;
      in_valid_d  = (state_d == ST_ISSUE);
      rsp_valid_d = (state_d == ST_RESP);
   end

   // FSM state, counters and response/handshake registers.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking (<=) so every register samples
      // pre-edge values regardless of statement order.
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         pending_q   <= 1'b0;
         version_q   <= '0;
         req_ready_q <= 1'b0;
         in_valid_q  <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_dec_q   <= '0;
         rsp_pred_q  <= 1'b0;
         rsp_tag_q   <= '0;
         rsp_tmo_q   <= 1'b0;
         feat_q      <= '0;
         tag_q       <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         pending_q   <= pending_d;
         version_q   <= version_d;
         req_ready_q <= req_ready_d;
         in_valid_q  <= in_valid_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_dec_q   <= rsp_dec_d;
         rsp_pred_q  <= rsp_pred_d;
         rsp_tag_q   <= rsp_tag_d;
         rsp_tmo_q   <= rsp_tmo_d;
         feat_q      <= feat_d;
         tag_q       <= tag_d;
      end
   end

   // Shadow model writes, shadow->active copy on commit, and cfg_err pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: the model storage is reset on purpose: kernel_svm must see a
      // defined all-zero model after reset, not whatever the flops powered up to.
      if (!rst_n) begin
         shadow_sv_q   <= '0;
         shadow_coef_q <= '0;
         shadow_bias_q <= '0;
         active_sv_q   <= '0;
         active_coef_q <= '0;
         active_bias_q <= '0;
         cfg_err_q     <= 1'b0;
      end else begin
         cfg_err_q <= addr_oob;
         if (sv_wr)   shadow_sv_q[sv_idx*DATA_WIDTH +: DATA_WIDTH]     <= cfg_wdata;
         if (coef_wr) shadow_coef_q[coef_idx*DATA_WIDTH +: DATA_WIDTH] <= cfg_wdata;
         if (bias_wr) shadow_bias_q                                    <= cfg_wdata;
         // Commits are applied only in IDLE, so the active model is frozen
         // from ISSUE through the response handshake.
         if (apply_commit) begin
            active_sv_q   <= shadow_sv_q;
            active_coef_q <= shadow_coef_q;
            active_bias_q <= shadow_bias_q;
         end
      end
   end

   assign cfg_err            = cfg_err_q;
   assign model_version      = version_q;
   assign req_ready          = req_ready_q;
   assign rsp_valid          = rsp_valid_q;
   assign rsp_decision       = rsp_dec_q;
   assign rsp_prediction     = rsp_pred_q;
   assign rsp_tag            = rsp_tag_q;
   assign rsp_timeout        = rsp_tmo_q;
   assign svm_input_valid    = in_valid_q;
   assign svm_features_flat  = feat_q;
   assign svm_sv_flat        = active_sv_q;
   assign svm_dual_coef_flat = active_coef_q;
   assign svm_bias           = active_bias_q;

endmodule

// File: tb/tb_svm_infer_ctrl.sv
// Testbench for svm_infer_ctrl: kernel_svm is replaced by a latency-programmable
// stub; a word-array model of shadow/active configuration and a per-request
// expectation (answer vs timeout, latency, fields) supply expected values.
module tb_svm_infer_ctrl;

   localparam int DW   = 16;
   localparam int NF   = 16;
   localparam int NSV  = 16;
   localparam int AW   = 9;
   localparam int TW   = 4;
   localparam int TMO  = 32;
   localparam int FW   = DW * NF;
   localparam int SVW  = DW * NF * NSV;
   localparam int CW   = DW * NSV;
   localparam int BIAS = NF * NSV + NSV;   // 272

   logic            clk = 1'b0;
   logic            rst_n;
   logic            cfg_wr_en;
   logic [AW-1:0]   cfg_addr;
   logic [DW-1:0]   cfg_wdata;
   logic            cfg_commit;
   logic            cfg_err;
   logic [7:0]      model_version;
   logic            req_valid;
   logic            req_ready;
   logic [FW-1:0]   req_features_flat;
   logic [TW-1:0]   req_tag;
   logic            rsp_valid;
   logic            rsp_ready;
   logic [DW-1:0]   rsp_decision;
   logic            rsp_prediction;
   logic [TW-1:0]   rsp_tag;
   logic            rsp_timeout;
   logic            svm_input_valid;
   logic [FW-1:0]   svm_features_flat;
   logic [SVW-1:0]  svm_sv_flat;
   logic [CW-1:0]   svm_dual_coef_flat;
   logic [DW-1:0]   svm_bias;
   logic            svm_output_valid;
   logic [DW-1:0]   svm_decision_value;
   logic            svm_prediction;

   int checks   = 0;
   int failures = 0;

   // configuration model: word-addressed exactly like cfg_addr
   logic [DW-1:0] m_shadow [0:BIAS];
   logic [DW-1:0] m_active [0:BIAS];
   logic [7:0]    m_version;
   bit            m_pending;

   // stub controls (written by the main sequence, read by the stub)
   int            stub_lat;
   logic [DW-1:0] stub_dec;
   logic          stub_pred;
   int            stub_cnt;

   svm_infer_ctrl #(
      .DATA_WIDTH(DW), .NUM_FEATURES(NF), .NUM_SUPPORT_VECTORS(NSV),
      .ADDR_W(AW), .TAG_W(TW), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .cfg_wr_en(cfg_wr_en), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
      .cfg_commit(cfg_commit), .cfg_err(cfg_err), .model_version(model_version),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_features_flat(req_features_flat), .req_tag(req_tag),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_decision(rsp_decision),
      .rsp_prediction(rsp_prediction), .rsp_tag(rsp_tag), .rsp_timeout(rsp_timeout),
      .svm_input_valid(svm_input_valid), .svm_features_flat(svm_features_flat),
      .svm_sv_flat(svm_sv_flat), .svm_dual_coef_flat(svm_dual_coef_flat),
      .svm_bias(svm_bias), .svm_output_valid(svm_output_valid),
      .svm_decision_value(svm_decision_value), .svm_prediction(svm_prediction)
   );

   always #5 clk = ~clk;

   // kernel_svm stub: answers stub_lat cycles after the input_valid cycle (0 = never)
   initial begin
      svm_output_valid   = 1'b0;
      svm_decision_value = '0;
      svm_prediction     = 1'b0;
      stub_cnt           = 0;
      forever begin
         @(negedge clk);
         svm_output_valid = 1'b0;
         if (!rst_n) begin
            stub_cnt = 0;
         end else begin
            if (stub_cnt > 0) begin
               stub_cnt--;
               if (stub_cnt == 0) begin
                  svm_output_valid   = 1'b1;
                  svm_decision_value = stub_dec;
                  svm_prediction     = stub_pred;
               end
            end
            if (svm_input_valid === 1'b1) stub_cnt = stub_lat;
         end
      end
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish, required completion within 1ms");
      $fatal(1, "watchdog");
   end

   function automatic void m_reset();
      for (int a = 0; a <= BIAS; a++) begin
         m_shadow[a] = '0;
         m_active[a] = '0;
      end
      m_version = '0;
      m_pending = 1'b0;
   endfunction

   function automatic void m_apply();
      for (int a = 0; a <= BIAS; a++) m_active[a] = m_shadow[a];
      m_version = m_version + 8'd1;
      m_pending = 1'b0;
   endfunction

   function automatic bit model_match();
      logic [SVW-1:0] sv;
      logic [CW-1:0]  co;
      for (int a = 0; a < NF * NSV; a++) sv[a*DW +: DW] = m_active[a];
      for (int j = 0; j < NSV; j++)      co[j*DW +: DW] = m_active[NF*NSV + j];
      return (svm_sv_flat === sv) && (svm_dual_coef_flat === co) &&
             (svm_bias === m_active[BIAS]) && (model_version === m_version);
   endfunction

   task automatic cfg_write(input int a, input logic [DW-1:0] d);
      cfg_wr_en = 1'b1;
      cfg_addr  = a[AW-1:0];
      cfg_wdata = d;
      if (a <= BIAS) m_shadow[a] = d;
      @(negedge clk);
      cfg_wr_en = 1'b0;
   endtask

   // commit issued while idle: one apply cycle with req_ready low, then visible
   task automatic commit_idle();
      cfg_commit = 1'b1;
      m_pending  = 1'b1;
      @(negedge clk);
      cfg_commit = 1'b0;
      checks++;
      if (req_ready !== 1'b0) begin
         failures++;
         $display("FAIL commit_apply_ready: req_ready=%b required 0", req_ready);
      end
      m_apply();
      @(negedge clk);
      checks++;
      if (!model_match() || req_ready !== 1'b1) begin
         failures++;
         $display("FAIL commit_visible: version=%0d/%0d bias=%h/%h sv0=%h/%h ready=%b/1",
                  model_version, m_version, svm_bias, m_active[BIAS],
                  svm_sv_flat[DW-1:0], m_active[0], req_ready);
      end
   endtask

   // one full transaction with expectations derived from latency vs timeout limit
   task automatic do_request(input logic [TW-1:0] tag, input logic [FW-1:0] feats,
                             input int lat, input logic [DW-1:0] dec, input logic pred,
                             input int hold, input int commit_at);
      bit            exp_tmo;
      logic [DW-1:0] exp_dec;
      logic          exp_pred;
      int            exp_lat;
      int            n;
      int            cyc;
      exp_tmo  = (lat == 0) || (lat > TMO);
      exp_dec  = exp_tmo ? '0 : dec;
      exp_pred = exp_tmo ? 1'b0 : pred;
      exp_lat  = exp_tmo ? TMO + 1 : lat + 1;
      stub_lat  = lat;
      stub_dec  = dec;
      stub_pred = pred;
      req_features_flat = feats;
      req_tag   = tag;
      req_valid = 1'b1;
      n = 0;
      while (req_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= 50) begin
         failures++;
         $display("FAIL req_accept: req_ready=%b after %0d cycles, required 1", req_ready, n);
         req_valid = 1'b0;
         return;
      end
      @(negedge clk);
      req_valid = 1'b0;
      req_features_flat = {8{$urandom()}};
      req_tag = TW'($urandom());
      checks++;
      if (svm_input_valid !== 1'b1 || req_ready !== 1'b0) begin
         failures++;
         $display("FAIL issue: input_valid=%b req_ready=%b required 1/0", svm_input_valid, req_ready);
      end
      checks++;
      if (svm_features_flat !== feats) begin
         failures++;
         $display("FAIL features: word0=%h required %h", svm_features_flat[DW-1:0], feats[DW-1:0]);
      end
      cyc = 0;
      while (rsp_valid !== 1'b1 && cyc < 100) begin
         @(negedge clk);
         cyc++;
         cfg_commit = (commit_at != 0) && (cyc == commit_at);
         if (cfg_commit) m_pending = 1'b1;
         checks++;
         if (svm_input_valid !== 1'b0 || req_ready !== 1'b0 || !model_match()) begin
            failures++;
            $display("FAIL in_flight: cyc=%0d input_valid=%b/0 req_ready=%b/0 bias=%h/%h version=%0d/%0d",
                     cyc, svm_input_valid, req_ready, svm_bias, m_active[BIAS], model_version, m_version);
         end
      end
      cfg_commit = 1'b0;
      checks++;
      if (cyc != exp_lat) begin
         failures++;
         $display("FAIL rsp_latency: rsp_valid after %0d cycles, required %0d", cyc, exp_lat);
      end
      checks++;
      if ({rsp_decision, rsp_prediction, rsp_tag, rsp_timeout} !== {exp_dec, exp_pred, tag, exp_tmo}) begin
         failures++;
         $display("FAIL rsp_fields: dec=%h/%h pred=%b/%b tag=%0d/%0d timeout=%b/%b",
                  rsp_decision, exp_dec, rsp_prediction, exp_pred, rsp_tag, tag, rsp_timeout, exp_tmo);
      end
      rsp_ready = 1'b0;
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         checks++;
         if (rsp_valid !== 1'b1 || req_ready !== 1'b0 ||
             {rsp_decision, rsp_prediction, rsp_tag, rsp_timeout} !== {exp_dec, exp_pred, tag, exp_tmo}) begin
            failures++;
            $display("FAIL rsp_hold: h=%0d valid=%b/1 ready=%b/0 dec=%h/%h timeout=%b/%b",
                     h, rsp_valid, req_ready, rsp_decision, exp_dec, rsp_timeout, exp_tmo);
         end
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      checks++;
      if (rsp_valid !== 1'b0) begin
         failures++;
         $display("FAIL rsp_release: rsp_valid=%b required 0", rsp_valid);
      end
      if (m_pending) begin
         checks++;
         if (req_ready !== 1'b0 || !model_match()) begin
            failures++;
            $display("FAIL commit_hold: req_ready=%b/0 bias=%h/%h version=%0d/%0d",
                     req_ready, svm_bias, m_active[BIAS], model_version, m_version);
         end
         m_apply();
         @(negedge clk);
      end
      checks++;
      if (req_ready !== 1'b1 || !model_match()) begin
         failures++;
         $display("FAIL idle_ready: req_ready=%b/1 bias=%h/%h version=%0d/%0d",
                  req_ready, svm_bias, m_active[BIAS], model_version, m_version);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      m_reset();
      @(negedge clk);
      @(negedge clk);
      checks++;
      if ({cfg_err, model_version, req_ready, rsp_valid, rsp_decision, rsp_prediction,
           rsp_tag, rsp_timeout, svm_input_valid} !== '0 ||
          svm_features_flat !== '0 || !model_match()) begin
         failures++;
         $display("FAIL reset_outputs: version=%0d ready=%b rsp_valid=%b in_valid=%b bias=%h, all required 0",
                  model_version, req_ready, rsp_valid, svm_input_valid, svm_bias);
      end
      rst_n = 1'b1;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_ready: req_ready=%b required 1", req_ready);
      end
   endtask

   task automatic test_config_commit();
      for (int i = 0; i < NF; i++) cfg_write(i, 16'h0100);
      cfg_write(256, 16'h0100);
      cfg_write(BIAS, 16'h0000);
      for (int k = 0; k < 6; k++) cfg_write($urandom_range(NF, BIAS - 1), DW'($urandom()));
      commit_idle();
      checks++;
      if (model_version !== 8'd1 || svm_sv_flat[DW-1:0] !== 16'h0100 ||
          svm_dual_coef_flat[DW-1:0] !== 16'h0100) begin
         failures++;
         $display("FAIL first_commit: version=%0d/1 sv0=%h/0100 coef0=%h/0100",
                  model_version, svm_sv_flat[DW-1:0], svm_dual_coef_flat[DW-1:0]);
      end
   endtask

   task automatic test_basic_request();
      do_request(4'd3, {NF{16'h0100}}, 6, 16'h0100, 1'b1, 0, 0);
   endtask

   task automatic test_back_pressure();
      do_request(TW'($urandom()), {8{$urandom()}}, 4, DW'($urandom()), 1'($urandom()), 5, 0);
   endtask

   task automatic test_commit_during_wait();
      cfg_write(BIAS, 16'h0080);
      do_request(4'd9, {8{$urandom()}}, 10, 16'hff00, 1'b0, 2, 4);
      checks++;
      if (model_version !== 8'd2 || svm_bias !== 16'h0080) begin
         failures++;
         $display("FAIL wait_commit: version=%0d/2 bias=%h/0080", model_version, svm_bias);
      end
   endtask

   task automatic test_timeout();
      // never-in-time answer, late pulse lands while the response is held
      do_request(4'd5, {8{$urandom()}}, 40, 16'h7fff, 1'b1, 12, 0);
      // boundary: answer exactly at the limit wins, one cycle later times out
      do_request(4'd6, {8{$urandom()}}, TMO, 16'h1234, 1'b1, 0, 0);
      do_request(4'd7, {8{$urandom()}}, TMO + 1, 16'h4321, 1'b1, 0, 0);
      do_request(4'd8, {8{$urandom()}}, 0, 16'h5555, 1'b1, 1, 0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checks++;
         if (rsp_valid !== 1'b0 || svm_input_valid !== 1'b0) begin
            failures++;
            $display("FAIL late_ignored: rsp_valid=%b in_valid=%b required 0/0", rsp_valid, svm_input_valid);
         end
      end
   endtask

   task automatic test_cfg_err();
      cfg_write(300, 16'hdead);
      checks++;
      if (cfg_err !== 1'b1) begin
         failures++;
         $display("FAIL cfg_err_300: cfg_err=%b required 1", cfg_err);
      end
      @(negedge clk);
      checks++;
      if (cfg_err !== 1'b0) begin
         failures++;
         $display("FAIL cfg_err_pulse: cfg_err=%b required 0", cfg_err);
      end
      cfg_write(BIAS + 1, 16'hbeef);
      checks++;
      if (cfg_err !== 1'b1) begin
         failures++;
         $display("FAIL cfg_err_273: cfg_err=%b required 1", cfg_err);
      end
      cfg_write(BIAS, 16'h0055);
      checks++;
      if (cfg_err !== 1'b0) begin
         failures++;
         $display("FAIL cfg_err_272: cfg_err=%b required 0", cfg_err);
      end
      commit_idle();
   endtask

   task automatic test_random();
      int lat;
      int elat;
      int cat;
      for (int it = 0; it < 10; it++) begin
         for (int k = 0; k < 3; k++) cfg_write($urandom_range(0, BIAS), DW'($urandom()));
         if (it % 4 == 3) commit_idle();
         lat  = $urandom_range(1, TMO + 2);
         elat = (lat > TMO) ? TMO + 1 : lat + 1;
         cat  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, elat - 1) : 0;
         do_request(TW'($urandom()), {8{$urandom()}}, lat, DW'($urandom()), 1'($urandom()),
                    $urandom_range(0, 3), cat);
      end
   endtask

   task automatic test_reset_mid();
      int n;
      stub_lat  = 0;
      req_features_flat = {8{$urandom()}};
      req_tag   = 4'd2;
      req_valid = 1'b1;
      n = 0;
      while (req_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      req_valid = 1'b0;
      repeat (5) @(negedge clk);
      cfg_write(BIAS, 16'h1234);
      cfg_commit = 1'b1;
      @(negedge clk);
      cfg_commit = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      m_reset();
      checks++;
      if ({cfg_err, model_version, req_ready, rsp_valid, rsp_decision, rsp_prediction,
           rsp_tag, rsp_timeout, svm_input_valid} !== '0 ||
          svm_features_flat !== '0 || !model_match()) begin
         failures++;
         $display("FAIL reset_mid_outputs: version=%0d ready=%b rsp_valid=%b bias=%h sv0=%h, all required 0",
                  model_version, req_ready, rsp_valid, svm_bias, svm_sv_flat[DW-1:0]);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      do_request(4'd11, {8{$urandom()}}, 7, 16'h0a0a, 1'b1, 0, 0);
      checks++;
      if (model_version !== 8'd0 || svm_bias !== 16'h0000) begin
         failures++;
         $display("FAIL pending_discarded: version=%0d/0 bias=%h/0000", model_version, svm_bias);
      end
   endtask

   initial begin
      rst_n             = 1'b0;
      cfg_wr_en         = 1'b0;
      cfg_addr          = '0;
      cfg_wdata         = '0;
      cfg_commit        = 1'b0;
      req_valid         = 1'b0;
      req_features_flat = '0;
      req_tag           = '0;
      rsp_ready         = 1'b0;
      stub_lat          = 0;
      stub_dec          = '0;
      stub_pred         = 1'b0;
      test_reset();
      test_config_commit();
      test_basic_request();
      test_back_pressure();
      test_commit_during_wait();
      test_timeout();
      test_cfg_err();
      test_random();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
